// File: rtl/tt_um_btn_reader_jellyant.sv
// Push-button reader: synchronises, debounces and edge-detects 8 buttons,
// counts presses per channel and shows either the levels or one channel's count.
module tt_um_btn_reader_jellyant #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       sel;
  logic             view;
  logic             clr;
  logic [7:0]       sync_meta;
  logic [7:0]       sync_s;
  logic [7:0]       db;
  logic [7:0]       db_nxt;
  logic [7:0]       db_prev;
  logic [7:0]       press;
  logic             press_q;
  logic [CNT_W-1:0] db_cnt     [8];
  logic [CNT_W-1:0] db_cnt_nxt [8];
  logic [7:0]       press_cnt  [8];
  logic [7:0]       ovf;
  logic             unused_bits;

  assign sel         = uio_in[2:0];
  assign view        = uio_in[3];
  assign clr         = uio_in[4];
  assign unused_bits = &{1'b0, ena, uio_in[7:5]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync_s    <= '0;
    end else begin
      sync_meta <= ui_in;
      sync_s    <= sync_meta;
    end
  end

  // A channel's level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      db_nxt[i]     = db[i];
      db_cnt_nxt[i] = '0;
      if (sync_s[i] != db[i]) begin
        if (db_cnt[i] == CNT_LAST) begin
          db_nxt[i] = sync_s[i];
        end else begin
          db_cnt_nxt[i] = db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db      <= '0;
      db_prev <= '0;
      press_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      db      <= db_nxt;
      db_prev <= db;
      press_q <= |press;
      for (int i = 0; i < 8; i++) begin
        db_cnt[i] <= db_cnt_nxt[i];
      end
    end
  end

  assign press = db & ~db_prev;

  // Clear of the selected channel takes priority over a press arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= '0;
      for (int i = 0; i < 8; i++) begin
        press_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (clr && (sel == 3'(i))) begin
          press_cnt[i] <= '0;
          ovf[i]       <= 1'b0;
        end else if (press[i]) begin
          press_cnt[i] <= press_cnt[i] + 8'd1;
          if (press_cnt[i] == 8'hFF) begin
            ovf[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign uo_out  = view ? press_cnt[sel] : db;
  assign uio_out = {|db, press_q, ovf[sel], 5'b0_0000};
  assign uio_oe  = 8'b1110_0000;

endmodule

// File: tb/tb_tt_um_btn_reader_jellyant.sv
// Directed bench for the button reader: a small press-count model feeds a
// scoreboard queue of expected values that are popped when outputs are sampled.
module tb_tt_um_btn_reader_jellyant;

  localparam int DB_CYC = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int         test_count = 0;
  int         fail_count = 0;
  logic [7:0] exp_q [$];
  string      tag_q [$];
  logic [7:0] m_cnt [8];
  logic       m_ovf [8];

  tt_um_btn_reader_jellyant #(
    .DEBOUNCE_CYCLES(DB_CYC),
    .CNT_W          (5)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ctl(input logic [2:0] sel, input logic view, input logic clr);
    return {3'b000, clr, view, sel};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_cnt[i] = 8'd0;
      m_ovf[i] = 1'b0;
    end
  endtask

  task automatic model_press(input int ch);
    m_cnt[ch] = m_cnt[ch] + 8'd1;
    if (m_cnt[ch] == 8'd0) m_ovf[ch] = 1'b1;
  endtask

  task automatic expect_value(input string tag, input logic [7:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic checkOutput(input logic [7:0] obs);
    logic [7:0] exp_v;
    string      tag;
    test_count++;
    if (exp_q.size() == 0) begin
      fail_count++;
      $display("[TB] FAIL scoreboard_empty observed=%h expected=none", obs);
      return;
    end
    exp_v = exp_q.pop_front();
    tag   = tag_q.pop_front();
    assert (obs === exp_v) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] ui, input logic [7:0] uio, input int cycles);
    ui_in  = ui;
    uio_in = uio;
    tick(cycles);
  endtask

  // One clean press-and-release of every channel in mask, long enough to debounce both ways.
  task automatic press_buttons(input logic [7:0] mask, input logic [7:0] ctl_val);
    applyStimulus(mask, ctl_val, DB_CYC + 4);
    for (int ch = 0; ch < 8; ch++) begin
      if (mask[ch]) model_press(ch);
    end
    applyStimulus(8'h00, ctl_val, DB_CYC + 4);
  endtask

  task automatic check_count(input string tag, input int ch);
    uio_in = ctl(3'(ch), 1'b1, 1'b0);
    #1;
    expect_value(tag, m_cnt[ch]);
    checkOutput(uo_out);
  endtask

  initial begin
    ena    = 1'b1;
    rst_n  = 1'b0;
    ui_in  = 8'hFF;
    uio_in = 8'h00;
    model_reset();
    tick(2);
    expect_value("reset_uo", 8'h00);   checkOutput(uo_out);
    expect_value("reset_uio", 8'h00);  checkOutput(uio_out);
    expect_value("reset_oe", 8'hE0);   checkOutput(uio_oe);

    rst_n = 1'b1;
    tick(DB_CYC + 1);
    expect_value("rst_db_early", 8'h00); checkOutput(uo_out);
    tick(1);
    expect_value("rst_db_set", 8'hFF);   checkOutput(uo_out);
    for (int ch = 0; ch < 8; ch++) model_press(ch);
    tick(1);
    expect_value("rst_press_hi", 8'hC0); checkOutput(uio_out);
    tick(1);
    expect_value("rst_press_lo", 8'h80); checkOutput(uio_out);
    check_count("rst_cnt_ch5", 5);

    applyStimulus(8'h00, 8'h00, DB_CYC + 4);
    expect_value("release_uo", 8'h00);  checkOutput(uo_out);
    expect_value("release_uio", 8'h00); checkOutput(uio_out);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    model_reset();
    tick(1);

    applyStimulus(8'h04, 8'h00, DB_CYC + 1);
    expect_value("clean_early", 8'h00); checkOutput(uo_out);
    tick(1);
    expect_value("clean_db", 8'h04);    checkOutput(uo_out);
    model_press(2);
    tick(1);
    expect_value("clean_press_hi", 8'hC0); checkOutput(uio_out);
    tick(1);
    expect_value("clean_press_lo", 8'h80); checkOutput(uio_out);
    check_count("clean_cnt_ch2", 2);
    applyStimulus(8'h00, 8'h00, DB_CYC + 4);

    applyStimulus(8'h01, 8'h00, 3);
    applyStimulus(8'h00, 8'h00, 1);
    applyStimulus(8'h01, 8'h00, 3);
    applyStimulus(8'h00, 8'h00, DB_CYC + 4);
    expect_value("bounce_db", 8'h00); checkOutput(uo_out);
    check_count("bounce_cnt_ch0", 0);

    press_buttons(8'h08, 8'h00);
    check_count("pre_race_ch3", 3);
    applyStimulus(8'h48, 8'h00, DB_CYC + 2);
    applyStimulus(8'h48, ctl(3'd3, 1'b0, 1'b1), 1);
    m_cnt[3] = 8'd0;
    m_ovf[3] = 1'b0;
    model_press(6);
    applyStimulus(8'h00, 8'h00, DB_CYC + 4);
    check_count("race_ch3", 3);
    check_count("race_ch6", 6);
    check_count("race_ch2", 2);

    for (int k = 0; k < 255; k++) press_buttons(8'h20, ctl(3'd5, 1'b1, 1'b0));
    #1;
    expect_value("cnt_255", m_cnt[5]);  checkOutput(uo_out);
    expect_value("ovf_before", {2'b00, m_ovf[5], 5'b0}); checkOutput(uio_out);
    press_buttons(8'h20, ctl(3'd5, 1'b1, 1'b0));
    #1;
    expect_value("wrap_cnt", m_cnt[5]); checkOutput(uo_out);
    expect_value("wrap_ovf", {2'b00, m_ovf[5], 5'b0}); checkOutput(uio_out);
    uio_in = ctl(3'd4, 1'b1, 1'b0);
    #1;
    expect_value("ovf_other_ch", {2'b00, m_ovf[4], 5'b0}); checkOutput(uio_out);
    applyStimulus(8'h00, ctl(3'd5, 1'b1, 1'b1), 1);
    m_cnt[5] = 8'd0;
    m_ovf[5] = 1'b0;
    uio_in = ctl(3'd5, 1'b1, 1'b0);
    #1;
    expect_value("ovf_cleared", 8'h00); checkOutput(uio_out);

    applyStimulus(8'h80, 8'h00, DB_CYC + 4);
    model_press(7);
    expect_value("pre_async_uo", 8'h80); checkOutput(uo_out);
    applyStimulus(8'h82, 8'h00, 3);
    #1 rst_n = 1'b0;
    #1;
    expect_value("async_uo", 8'h00);  checkOutput(uo_out);
    expect_value("async_uio", 8'h00); checkOutput(uio_out);
    rst_n = 1'b1;
    model_reset();
    check_count("async_cnt_ch2", 2);
    @(negedge clk);
    uio_in = 8'h00;
    tick(DB_CYC + 4);
    model_press(1);
    model_press(7);
    check_count("restart_ch7", 7);
    check_count("restart_ch1", 1);
    applyStimulus(8'h00, 8'h00, 2);

    if (exp_q.size() != 0) begin
      test_count++;
      fail_count++;
      $display("[TB] FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
